vga_sync_gen: RTL and testbench

Generates 640x480 @ 60 Hz VGA timing from the system clock.
- Drives `hsync`/`vsync` to the connector.
- Supplies `video_on`, `pix_x` and `pix_y` to the pixel-graph generators, which map coordinates to `graph_rgb`.
- Divides the system clock into a pixel-rate enable, `p_tick`, that all pixel-rate logic uses.
- Emits per-line and per-frame strobes for animation and state updates.

---
 rtl/vga_timing_pkg.sv | 25 ++
 rtl/vga_sync_gen_if.sv | 17 +
 rtl/pixel_tick_div.sv | 23 ++
 rtl/vga_sync_gen.sv | 84 ++++++++
 tb/tb_vga_sync_gen.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_pkg.sv
// VGA 640x480@60 timing constants shared by the sync generator and the pixel-graph modules.
// The graph modules use the same screen bounds, so they import this package too.
package vga_timing_pkg;

   localparam int COORD_W = 10;

   localparam int DEF_H_DISPLAY = 640;
   localparam int DEF_H_FRONT   = 16;
   localparam int DEF_H_SYNC    = 96;
   localparam int DEF_H_BACK    = 48;
   localparam int DEF_V_DISPLAY = 480;
   localparam int DEF_V_FRONT   = 10;
   localparam int DEF_V_SYNC    = 2;
   localparam int DEF_V_BACK    = 33;

   typedef logic [COORD_W-1:0] coord_t;

   function automatic int span_total(input int disp, input int front, input int sync, input int back);
      return disp + front + sync + back;
   endfunction

   localparam int H_TOTAL = span_total(DEF_H_DISPLAY, DEF_H_FRONT, DEF_H_SYNC, DEF_H_BACK);
   localparam int V_TOTAL = span_total(DEF_V_DISPLAY, DEF_V_FRONT, DEF_V_SYNC, DEF_V_BACK);

endpackage

// File: rtl/vga_sync_gen_if.sv
// Timing bundle from the sync generator to the connector and the pixel-graph generators.
interface vga_sync_gen_if;
   import vga_timing_pkg::*;

   logic   hsync;
   logic   vsync;
   logic   video_on;
   logic   p_tick;
   coord_t pix_x;
   coord_t pix_y;
   logic   line_end;
   logic   frame_end;

   modport master (output hsync, vsync, video_on, p_tick, pix_x, pix_y, line_end, frame_end);
   modport slave  (input  hsync, vsync, video_on, p_tick, pix_x, pix_y, line_end, frame_end);

endinterface

// File: rtl/pixel_tick_div.sv
// Divides clk into a one-clk-wide pixel enable every CLK_DIV cycles.
module pixel_tick_div #(
   parameter int CLK_DIV = 2
)(
   input  logic clk,
   input  logic reset,
   output logic p_tick
);

   // A 1-bit counter pinned at zero makes CLK_DIV=1 give a constant tick with no special case.
   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] LAST = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (reset || r_cnt == LAST) r_cnt <= '0;
      else                        r_cnt <= r_cnt + 1'b1;
   end

   assign p_tick = (r_cnt == LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// Free-running VGA timing: pixel/line counters, registered syncs aligned to the counters,
// and line/frame strobes.
module vga_sync_gen
   import vga_timing_pkg::*;
#(
   parameter int CLK_DIV   = 2,
   parameter int H_DISPLAY = DEF_H_DISPLAY,
   parameter int H_FRONT   = DEF_H_FRONT,
   parameter int H_SYNC    = DEF_H_SYNC,
   parameter int H_BACK    = DEF_H_BACK,
   parameter int V_DISPLAY = DEF_V_DISPLAY,
   parameter int V_FRONT   = DEF_V_FRONT,
   parameter int V_SYNC    = DEF_V_SYNC,
   parameter int V_BACK    = DEF_V_BACK
)(
   input  logic           clk,
   input  logic           reset,
   vga_sync_gen_if.master o_vga
);

   localparam int H_TOT = span_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
   localparam int V_TOT = span_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);

   localparam coord_t H_LAST = coord_t'(H_TOT - 1);
   localparam coord_t V_LAST = coord_t'(V_TOT - 1);
   localparam coord_t H_VIS  = coord_t'(H_DISPLAY);
   localparam coord_t V_VIS  = coord_t'(V_DISPLAY);
   localparam coord_t HS_BEG = coord_t'(H_DISPLAY + H_FRONT);
   localparam coord_t HS_END = coord_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
   localparam coord_t VS_BEG = coord_t'(V_DISPLAY + V_FRONT);
   localparam coord_t VS_END = coord_t'(V_DISPLAY + V_FRONT + V_SYNC - 1);

   logic   w_p_tick;
   logic   w_h_last;
   logic   w_line_end;
   coord_t w_h_nxt;
   coord_t w_v_nxt;
   coord_t r_h_cnt;
   coord_t r_v_cnt;
   logic   r_hsync;
   logic   r_vsync;

   pixel_tick_div #(.CLK_DIV(CLK_DIV)) u_div (
      .clk    (clk),
      .reset  (reset),
      .p_tick (w_p_tick)
   );

   always_comb begin
      w_h_nxt    = r_h_cnt;
      w_v_nxt    = r_v_cnt;
      w_h_last   = (r_h_cnt == H_LAST);
      w_line_end = w_p_tick && w_h_last;
      if (w_p_tick) begin
         w_h_nxt = w_h_last ? '0 : r_h_cnt + 1'b1;
         if (w_h_last) w_v_nxt = (r_v_cnt == V_LAST) ? '0 : r_v_cnt + 1'b1;
      end
   end

   // Syncs decode the next-state counts so their edges land on the same clk as the count change.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_h_cnt <= '0;
         r_v_cnt <= '0;
         r_hsync <= 1'b1;
         r_vsync <= 1'b1;
      end else begin
         r_h_cnt <= w_h_nxt;
         r_v_cnt <= w_v_nxt;
         r_hsync <= !(w_h_nxt >= HS_BEG && w_h_nxt <= HS_END);
         r_vsync <= !(w_v_nxt >= VS_BEG && w_v_nxt <= VS_END);
      end
   end

   assign o_vga.hsync     = r_hsync;
   assign o_vga.vsync     = r_vsync;
   assign o_vga.p_tick    = w_p_tick;
   assign o_vga.pix_x     = r_h_cnt;
   assign o_vga.pix_y     = r_v_cnt;
   assign o_vga.video_on  = (r_h_cnt < H_VIS) && (r_v_cnt < V_VIS);
   assign o_vga.line_end  = w_line_end;
   assign o_vga.frame_end = w_line_end && (r_v_cnt == V_LAST);

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench for vga_sync_gen: two instances (CLK_DIV=2 and CLK_DIV=1, short frames)
// checked every clk against an arithmetic timing model, plus pulse width/period measurements.
module tb_vga_sync_gen;

   localparam int HD = 640, HF = 16, HS = 96, HB = 48;
   localparam int VD = 4,   VF = 2,  VS = 2,  VB = 1;
   localparam int HT = HD + HF + HS + HB;
   localparam int VT = VD + VF + VS + VB;

   typedef struct packed {
      logic       hsync;
      logic       vsync;
      logic       video_on;
      logic       p_tick;
      logic [9:0] x;
      logic [9:0] y;
      logic       line_end;
      logic       frame_end;
   } obs_t;

   logic clk;
   logic rst;
   int   n_vec;
   int   n_bad;
   int   cyc;
   int   k;

   obs_t q0[$];
   obs_t q1[$];

   int last_le[2], last_fe[2], line_start[2], hlow[2], vlow[2];
   bit h_ok[2], v_ok[2], prev_h[2], prev_v[2];

   vga_sync_gen_if ifa ();
   vga_sync_gen_if ifb ();

   vga_sync_gen #(.CLK_DIV(2), .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
                  .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB))
      dut_a (.clk(clk), .reset(rst), .o_vga(ifa));

   vga_sync_gen #(.CLK_DIV(1), .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
                  .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB))
      dut_b (.clk(clk), .reset(rst), .o_vga(ifb));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // k = clk edges since the last edge that saw reset; pixel index = k / CLK_DIV.
   function automatic obs_t model(input int kk, input int d);
      obs_t o;
      int p, x, y;
      p = (kk / d) % (HT * VT);
      x = p % HT;
      y = p / HT;
      o.p_tick    = (kk % d) == d - 1;
      o.x         = 10'(x);
      o.y         = 10'(y);
      o.hsync     = !(x >= HD + HF && x < HD + HF + HS);
      o.vsync     = !(y >= VD + VF && y < VD + VF + VS);
      o.video_on  = (x < HD) && (y < VD);
      o.line_end  = o.p_tick && (x == HT - 1);
      o.frame_end = o.line_end && (y == VT - 1);
      return o;
   endfunction

   task automatic chk(input string name, input int d, input int act, input int exp_v);
      n_vec++;
      if (act != exp_v) begin
         n_bad++;
         $display("FAIL dut%0d %s @cyc %0d: got %0d, want %0d", d, name, cyc, act, exp_v);
      end
   endtask

   task automatic sample(input int d, input obs_t act);
      obs_t e;
      int   dv;
      dv = (d == 0) ? 2 : 1;
      if ((d == 0 ? q0.size() : q1.size()) == 0) begin
         n_vec++; n_bad++;
         $display("FAIL dut%0d scoreboard_empty @cyc %0d", d, cyc);
         return;
      end
      e = (d == 0) ? q0.pop_front() : q1.pop_front();
      n_vec++;
      if (act !== e) begin
         n_bad++;
         $display("FAIL dut%0d state @cyc %0d: got %h, want %h", d, cyc, act, e);
      end
      if (act.line_end) begin
         if (last_le[d] >= 0) chk("line_period", d, cyc - last_le[d], HT * dv);
         last_le[d] = cyc;
         line_start[d] = cyc + 1;
      end
      if (act.frame_end) begin
         if (last_fe[d] >= 0) chk("frame_period", d, cyc - last_fe[d], HT * VT * dv);
         last_fe[d] = cyc;
      end
      if (!act.hsync) begin
         if (prev_h[d]) begin
            h_ok[d] = 1'b1; hlow[d] = 0;
            if (line_start[d] >= 0) chk("hsync_fall_ofs", d, cyc - line_start[d], (HD + HF) * dv);
         end
         hlow[d]++;
      end else if (!prev_h[d] && h_ok[d]) begin
         chk("hsync_width", d, hlow[d], HS * dv);
         h_ok[d] = 1'b0;
      end
      if (!act.vsync) begin
         if (prev_v[d]) begin
            v_ok[d] = 1'b1; vlow[d] = 0;
            chk("vsync_fall_y", d, int'(act.y), VD + VF);
            chk("vsync_fall_at_line_start", d, cyc, line_start[d]);
         end
         vlow[d]++;
      end else if (!prev_v[d] && v_ok[d]) begin
         chk("vsync_width", d, vlow[d], VS * HT * dv);
         v_ok[d] = 1'b0;
      end
      prev_h[d] = act.hsync;
      prev_v[d] = act.vsync;
      // The next edge resets the DUT, so any open measurement is void.
      if (rst) begin
         last_le[d] = -1; last_fe[d] = -1; line_start[d] = cyc + 1;
         h_ok[d] = 1'b0; v_ok[d] = 1'b0;
      end
   endtask

   function automatic obs_t grab_a();
      obs_t o;
      o.hsync = ifa.hsync; o.vsync = ifa.vsync; o.video_on = ifa.video_on; o.p_tick = ifa.p_tick;
      o.x = ifa.pix_x; o.y = ifa.pix_y; o.line_end = ifa.line_end; o.frame_end = ifa.frame_end;
      return o;
   endfunction

   function automatic obs_t grab_b();
      obs_t o;
      o.hsync = ifb.hsync; o.vsync = ifb.vsync; o.video_on = ifb.video_on; o.p_tick = ifb.p_tick;
      o.x = ifb.pix_x; o.y = ifb.pix_y; o.line_end = ifb.line_end; o.frame_end = ifb.frame_end;
      return o;
   endfunction

   // Expected-value producer: one entry per edge per instance.
   initial begin
      k = 0;
      forever begin
         @(posedge clk);
         if (rst) k = 0;
         else     k++;
         q0.push_back(model(k, 2));
         q1.push_back(model(k, 1));
      end
   end

   // Monitor: compares on the falling edge, away from the active edge.
   initial begin
      cyc = 0;
      for (int d = 0; d < 2; d++) begin
         last_le[d] = -1; last_fe[d] = -1; line_start[d] = -1;
         hlow[d] = 0; vlow[d] = 0; h_ok[d] = 1'b0; v_ok[d] = 1'b0;
         prev_h[d] = 1'b1; prev_v[d] = 1'b1;
      end
      forever begin
         @(negedge clk);
         cyc++;
         sample(0, grab_a());
         sample(1, grab_b());
      end
   end

   initial begin
      int  tries;
      bit  hit;
      n_vec = 0;
      n_bad = 0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Two full frames of the CLK_DIV=2 instance.
      repeat (2 * HT * VT * 2 + 500) @(posedge clk);

      // Reset mid-hsync and mid-vsync at (700, VD+VF+1).
      hit = 1'b0;
      tries = 0;
      while (!hit && tries < 20000) begin
         @(posedge clk);
         #1;
         tries++;
         hit = (ifa.pix_x == 10'd700) && (ifa.pix_y == 10'(VD + VF + 1));
      end
      n_vec++;
      if (!hit) begin
         n_bad++;
         $display("FAIL wait_700_mid_vsync: not reached within %0d clk", tries);
      end
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (3000) @(posedge clk);

      // Randomised reset pulses across the frame.
      for (int s = 0; s < 15; s++) begin
         repeat ($urandom_range(50, 2500)) @(posedge clk);
         #1 rst = 1'b1;
         repeat ($urandom_range(1, 3)) @(posedge clk);
         #1 rst = 1'b0;
      end
      repeat (500) @(posedge clk);
      @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
